// File: rtl/tile_pkg.sv
// Shared definitions for the tile pixel streamer.
//   state_e       - sequencer states
//   TRI_*         - bit positions of color and depth in the 128-bit triangle word
//   CLEAR_DEPTH   - depth written on tile clear (farthest)
//   pack_pixel    - builds a {color, depth} buffer word
package tile_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StWaitTri,
        StPaint,
        StOutput
    } state_e;

    localparam int unsigned TRI_COLOR_HI = 127;
    localparam int unsigned TRI_COLOR_LO = 112;
    localparam int unsigned TRI_DEPTH_HI = 15;
    localparam int unsigned TRI_DEPTH_LO = 0;

    localparam logic [15:0] CLEAR_DEPTH = 16'hFFFF;

    function automatic logic [31:0] pack_pixel(input logic [15:0] color,
                                               input logic [15:0] depth);
        return {color, depth};
    endfunction

endpackage

// File: rtl/tile_buffer.sv
// Tile color/depth store: one registered read port, one write port.
//   clk              - clock
//   rd_en / rd_addr  - read request; rd_data updates only when rd_en is high
//   rd_data          - registered read data, one cycle after the request
//   wr_en / wr_addr / wr_data - write port, independent of the read port
module tile_buffer #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    logic [DW-1:0] mem [DEPTH];

    // rd_data holds between reads so the output stage can stall on it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/tile_pixel_streamer.sv
// Tile-pass sequencer for the painter pixel side.
//   clk, rst_n                       - clock, async active-low reset
//   start, tile_x, tile_y, num_tris  - tile request (sampled in idle)
//   busy, done                       - tile in progress / completion pulse
//   tri_in, tri_valid, tri_ready     - triangle queue handshake
//   px_*                             - pixel stream into the painter
//   pt_*                             - painter results written back to the buffer
//   out_*                            - finished tile colors in raster order
module tile_pixel_streamer
    import tile_pkg::*;
#(
    parameter int unsigned TILE_W    = 16,
    parameter int unsigned TILE_H    = 16,
    parameter int unsigned PAINT_LAT = 1,
    parameter logic [15:0] BG_COLOR  = 16'h0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [8:0]   tile_x,
    input  logic [7:0]   tile_y,
    input  logic [7:0]   num_tris,
    output logic         busy,
    output logic         done,
    input  logic [127:0] tri_in,
    input  logic         tri_valid,
    output logic         tri_ready,
    output logic [8:0]   px_x,
    output logic [7:0]   px_y,
    output logic [31:0]  px_data,
    output logic [127:0] px_triangle,
    output logic         px_valid,
    input  logic [8:0]   pt_x,
    input  logic [7:0]   pt_y,
    input  logic [31:0]  pt_data,
    input  logic         pt_valid,
    output logic [8:0]   out_x,
    output logic [7:0]   out_y,
    output logic [15:0]  out_color,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int unsigned N  = TILE_W * TILE_H;
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned XW = $clog2(TILE_W);
    localparam logic [AW:0] LAST = (AW + 1)'(N - 1);

    // A pixel must not be re-read before its previous write-back lands.
    if (N <= PAINT_LAT + 1) begin : g_lat_check
        $error("tile_pixel_streamer: tile too small for painter latency");
    end

    state_e        state_q;
    logic [AW:0]   cnt_q;       // clear / read address, MSB set once all N issued
    logic [AW:0]   wb_cnt_q;
    logic [7:0]    tris_left_q;
    logic [8:0]    tile_x_q;
    logic [7:0]    tile_y_q;

    logic [XW-1:0]    col;
    logic [AW-XW-1:0] row;
    logic [8:0]       cur_x;
    logic [7:0]       cur_y;

    assign col   = cnt_q[XW-1:0];
    assign row   = cnt_q[AW-1:XW];
    assign cur_x = tile_x_q + 9'(col);
    assign cur_y = tile_y_q + 8'(row);

    // Write-back address; modular subtraction matches the truncated px coordinates.
    logic [8:0]    dx;
    logic [7:0]    dy;
    logic          in_tile;
    logic [AW-1:0] wb_addr;

    assign dx      = pt_x - tile_x_q;
    assign dy      = pt_y - tile_y_q;
    assign in_tile = (dx < 9'(TILE_W)) && ({1'b0, dy} < 9'(TILE_H));
    assign wb_addr = {dy[AW-XW-1:0], dx[XW-1:0]};

    logic          rd_en;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data;

    always_comb begin
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = cnt_q[AW-1:0];
        wr_data = pack_pixel(BG_COLOR, CLEAR_DEPTH);
        unique case (state_q)
            StClear: wr_en = 1'b1;
            StPaint: begin
                rd_en   = !cnt_q[AW];
                wr_en   = pt_valid && in_tile;
                wr_addr = wb_addr;
                wr_data = pt_data;
            end
            StOutput: rd_en = !cnt_q[AW] && (!out_valid || out_ready);
            default: ;
        endcase
    end

    tile_buffer #(
        .DEPTH (N),
        .AW    (AW),
        .DW    (32)
    ) u_buffer (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_addr (cnt_q[AW-1:0]),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    // The RAM output register doubles as the px/out data register.
    assign px_data   = px_valid ? rd_data : 32'h0;
    assign out_color = out_valid ? rd_data[31:16] : 16'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wb_cnt_q    <= '0;
            tris_left_q <= '0;
            tile_x_q    <= '0;
            tile_y_q    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tri_ready   <= 1'b0;
            px_valid    <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            px_triangle <= '0;
            out_valid   <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
        end else begin
            done     <= 1'b0;
            px_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        tile_x_q    <= tile_x;
                        tile_y_q    <= tile_y;
                        tris_left_q <= num_tris;
                        cnt_q       <= '0;
                        busy        <= 1'b1;
                        state_q     <= StClear;
                    end
                end
                StClear: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_q <= '0;
                        if (tris_left_q != 8'd0) begin
                            tri_ready <= 1'b1;
                            state_q   <= StWaitTri;
                        end else begin
                            state_q   <= StOutput;
                        end
                    end
                end
                StWaitTri: begin
                    if (tri_valid) begin
                        px_triangle <= tri_in;
                        tris_left_q <= tris_left_q - 8'd1;
                        tri_ready   <= 1'b0;
                        cnt_q       <= '0;
                        wb_cnt_q    <= '0;
                        state_q     <= StPaint;
                    end
                end
                StPaint: begin
                    if (!cnt_q[AW]) begin
                        cnt_q    <= cnt_q + 1'b1;
                        px_valid <= 1'b1;
                        px_x     <= cur_x;
                        px_y     <= cur_y;
                    end
                    // Pass ends on the N-th write-back, dropped writes included.
                    if (pt_valid) begin
                        wb_cnt_q <= wb_cnt_q + 1'b1;
                        if (wb_cnt_q == LAST) begin
                            cnt_q <= '0;
                            if (tris_left_q != 8'd0) begin
                                tri_ready <= 1'b1;
                                state_q   <= StWaitTri;
                            end else begin
                                state_q   <= StOutput;
                            end
                        end
                    end
                end
                StOutput: begin
                    if (!out_valid || out_ready) begin
                        if (!cnt_q[AW]) begin
                            cnt_q     <= cnt_q + 1'b1;
                            out_valid <= 1'b1;
                            out_x     <= cur_x;
                            out_y     <= cur_y;
                        end else begin
                            out_valid <= 1'b0;
                            if (out_valid) begin
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                state_q <= StIdle;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_pixel_streamer.sv
module tb_tile_pixel_streamer;
    import tile_pkg::*;

    localparam int TW = 16;
    localparam int TH = 16;
    localparam int N  = TW * TH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [8:0]   tile_x = '0;
    logic [7:0]   tile_y = '0;
    logic [7:0]   num_tris = '0;
    logic         busy, done;
    logic [127:0] tri_in = '0;
    logic         tri_valid = 1'b0;
    logic         tri_ready;
    logic [8:0]   px_x;
    logic [7:0]   px_y;
    logic [31:0]  px_data;
    logic [127:0] px_triangle;
    logic         px_valid;
    logic [8:0]   pt_x;
    logic [7:0]   pt_y;
    logic [31:0]  pt_data;
    logic         pt_valid;
    logic [8:0]   out_x;
    logic [7:0]   out_y;
    logic [15:0]  out_color;
    logic         out_valid;
    logic         out_ready = 1'b1;

    tile_pixel_streamer #(
        .TILE_W    (TW),
        .TILE_H    (TH),
        .PAINT_LAT (1),
        .BG_COLOR  (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .tile_x      (tile_x),
        .tile_y      (tile_y),
        .num_tris    (num_tris),
        .busy        (busy),
        .done        (done),
        .tri_in      (tri_in),
        .tri_valid   (tri_valid),
        .tri_ready   (tri_ready),
        .px_x        (px_x),
        .px_y        (px_y),
        .px_data     (px_data),
        .px_triangle (px_triangle),
        .px_valid    (px_valid),
        .pt_x        (pt_x),
        .pt_y        (pt_y),
        .pt_data     (pt_data),
        .pt_valid    (pt_valid),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_color   (out_color),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int out_cnt = 0;
    int run_len = 0;
    bit stall_mode = 1'b0;
    logic [32:0]  exp_q[$];
    logic [15:0]  got_color[$];
    int           runs[$];
    int           run_start[$];
    logic [127:0] tri_list[4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Triangle: color/depth at package offsets; bench painter keeps an inclusive bbox
    // in [111:78] as x0, x1 (9b each), y0, y1 (8b each).
    function automatic logic [127:0] mk_tri(input logic [15:0] color, input logic [15:0] depth,
                                            input logic [8:0] x0, input logic [8:0] x1,
                                            input logic [7:0] y0, input logic [7:0] y1);
        logic [127:0] t;
        t = '0;
        t[TRI_COLOR_HI:TRI_COLOR_LO] = color;
        t[TRI_DEPTH_HI:TRI_DEPTH_LO] = depth;
        t[111:78] = {x0, x1, y0, y1};
        return t;
    endfunction

    function automatic logic [31:0] paint(input logic [127:0] t, input logic [8:0] x,
                                          input logic [7:0] y, input logic [31:0] d);
        logic [8:0] x0, x1;
        logic [7:0] y0, y1;
        {x0, x1, y0, y1} = t[111:78];
        if (x >= x0 && x <= x1 && y >= y0 && y <= y1 &&
            t[TRI_DEPTH_HI:TRI_DEPTH_LO] < d[15:0])
            return {t[TRI_COLOR_HI:TRI_COLOR_LO], t[TRI_DEPTH_HI:TRI_DEPTH_LO]};
        return d;
    endfunction

    // Painter model, latency 1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pt_valid <= 1'b0;
            pt_x     <= '0;
            pt_y     <= '0;
            pt_data  <= '0;
        end else begin
            pt_valid <= px_valid;
            pt_x     <= px_x;
            pt_y     <= px_y;
            pt_data  <= paint(px_triangle, px_x, px_y, px_data);
        end
    end

    initial forever begin
        @(posedge clk);
        #1 out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output scoreboard and px_valid run tracking.
    initial forever begin
        logic [32:0] e;
        @(negedge clk);
        if (!rst_n) begin
            run_len = 0;
        end else begin
            if (out_valid && out_ready) begin
                out_cnt++;
                got_color.push_back(out_color);
                if (exp_q.size() == 0) begin
                    check("out_extra", 256'd1, 256'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pixel", {223'd0, out_x, out_y, out_color}, {223'd0, e});
                end
            end
            if (px_valid) begin
                if (run_len == 0) run_start.push_back(cyc);
                run_len++;
            end else if (run_len != 0) begin
                runs.push_back(run_len);
                run_len = 0;
            end
        end
    end

    task automatic start_tile(input logic [8:0] tx, input logic [7:0] ty, input int nt,
                              output int t0);
        @(posedge clk);
        #1;
        tile_x = tx;
        tile_y = ty;
        num_tris = 8'(nt);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
        check("busy_after_start", {255'd0, busy}, 256'd1);
    endtask

    task automatic feed_tri(input logic [127:0] t, input int gap);
        bit px_seen;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (tri_ready) break;
        end
        check("tri_ready_wait", {255'd0, tri_ready}, 256'd1);
        px_seen = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (px_valid) px_seen = 1'b1;
        end
        if (gap > 0) check("px_idle_in_gap", {255'd0, px_seen}, 256'd0);
        tri_valid = 1'b1;
        tri_in = t;
        @(posedge clk);
        #1 tri_valid = 1'b0;
    endtask

    task automatic run_tile(input logic [8:0] tx, input logic [7:0] ty, input int nt,
                            input int gap, output int lat);
        int t0;
        exp_q.delete();
        got_color.delete();
        out_cnt = 0;
        for (int r = 0; r < TH; r++) begin
            for (int c = 0; c < TW; c++) begin
                logic [8:0]  x;
                logic [7:0]  y;
                logic [31:0] p;
                x = tx + 9'(c);
                y = ty + 8'(r);
                p = {16'h0000, 16'hFFFF};
                for (int k = 0; k < nt; k++) p = paint(tri_list[k], x, y, p);
                exp_q.push_back({x, y, p[31:16]});
            end
        end
        start_tile(tx, ty, nt, t0);
        for (int k = 0; k < nt; k++) feed_tri(tri_list[k], gap);
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (done) break;
        end
        lat = cyc - t0;
        check("done_seen", {255'd0, done}, 256'd1);
        check("busy_low_at_done", {255'd0, busy}, 256'd0);
        check("out_count", 256'(out_cnt), 256'(N));
        check("scoreboard_empty", 256'(exp_q.size()), 256'd0);
        @(negedge clk);
        check("done_one_cycle", {255'd0, done}, 256'd0);
    endtask

    initial begin
        int lat;
        int nbad;
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nbad;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {251'd0, busy, done, tri_ready, px_valid, out_valid}, 256'd0);
        check("reset_px", {79'd0, px_x, px_y, px_data, px_triangle}, 256'd0);
        check("reset_out", {223'd0, out_x, out_y, out_color}, 256'd0);
        rst_n = 1'b1;

        // Empty tile: background only; done lands 2N+1 edges after the start edge.
        run_tile(9'd32, 8'd16, 0, 0, lat);
        check("done_latency", 256'(lat), 256'(2 * N + 1));

        // Coordinate wrap at the top of the 9/8-bit range.
        run_tile(9'd504, 8'd248, 0, 0, lat);

        // One full-tile triangle.
        tri_list[0] = mk_tri(16'hF800, 16'd100, 9'd0, 9'd511, 8'd0, 8'd255);
        run_tile(9'd32, 8'd16, 1, 0, lat);
        nbad = 0;
        foreach (got_color[i]) if (got_color[i] !== 16'hF800) nbad++;
        check("full_tile_red", 256'(nbad), 256'd0);

        // Overlap: far A then near B, then reversed; B wins either way.
        tri_list[0] = mk_tri(16'h001F, 16'd200, 9'd32, 9'd39, 8'd16, 8'd23);
        tri_list[1] = mk_tri(16'h07E0, 16'd50, 9'd36, 9'd43, 8'd20, 8'd27);
        run_start.delete();
        runs.delete();
        run_tile(9'd32, 8'd16, 2, 0, lat);
        check("overlap_b", {240'd0, got_color[85]}, {240'd0, 16'h07E0});
        check("a_only", {240'd0, got_color[17]}, {240'd0, 16'h001F});
        check("pass_period", 256'(run_start[1] - run_start[0]), 256'(N + 3));
        tri_list[2] = tri_list[0];
        tri_list[0] = tri_list[1];
        tri_list[1] = tri_list[2];
        run_tile(9'd32, 8'd16, 2, 0, lat);
        check("overlap_b_rev", {240'd0, got_color[85]}, {240'd0, 16'h07E0});

        // Same scene under random backpressure.
        stall_mode = 1'b1;
        run_tile(9'd32, 8'd16, 2, 0, lat);
        stall_mode = 1'b0;

        // Delayed triangles: two separate 256-cycle px runs.
        runs.delete();
        run_tile(9'd32, 8'd16, 2, 40, lat);
        check("run_count", 256'(runs.size()), 256'd2);
        check("run0_len", 256'(runs[0]), 256'(N));
        check("run1_len", 256'(runs[1]), 256'(N));

        // Reset in the middle of the first pass.
        tri_list[0] = mk_tri(16'hF800, 16'd100, 9'd0, 9'd511, 8'd0, 8'd255);
        exp_q.delete();
        start_tile(9'd32, 8'd16, 1, lat);
        feed_tri(tri_list[0], 0);
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (run_len >= 100) break;
        end
        check("reached_mid_pass", 256'(run_len >= 100), 256'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_ctrl", {251'd0, busy, done, tri_ready, px_valid, out_valid}, 256'd0);
        check("midreset_px", {79'd0, px_x, px_y, px_data, px_triangle}, 256'd0);
        check("midreset_out", {223'd0, out_x, out_y, out_color}, 256'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_tile(9'd32, 8'd16, 1, 0, lat);
        nbad = 0;
        foreach (got_color[i]) if (got_color[i] !== 16'hF800) nbad++;
        check("after_reset_red", 256'(nbad), 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
